// File: rtl/frog_pkg.sv
// Shared codes for the frog movement controller: hop directions and FSM states.
package frog_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOP  = 2'd1,
    ST_COOL = 2'd2
  } state_t;

endpackage

// File: rtl/frog_cmd_latch.sv
// Key priority encoder (up > down > left > right) plus a one-entry pending
// command register that captures the first key seen while the hop FSM is busy.
module frog_cmd_latch
  import frog_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       busy,
  input  logic       consume,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic       cmd_valid,
  output logic [1:0] cmd_dir
);

  logic       any_key;
  logic [1:0] key_dir;
  logic       pend_valid;
  logic [1:0] pend_dir;

  always_comb begin
    any_key = key_up | key_down | key_left | key_right;
    key_dir = DIR_RIGHT;
    if (key_up)        key_dir = DIR_UP;
    else if (key_down) key_dir = DIR_DOWN;
    else if (key_left) key_dir = DIR_LEFT;
  end

  // First key while busy wins; later keys are dropped until the entry is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_dir   <= DIR_UP;
    end else if (clr) begin
      pend_valid <= 1'b0;
    end else if (busy) begin
      if (any_key && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_dir   <= key_dir;
      end
    end else if (consume) begin
      pend_valid <= 1'b0;
    end
  end

  // A buffered command always takes precedence over a fresh key in IDLE.
  assign cmd_valid = pend_valid | any_key;
  assign cmd_dir   = pend_valid ? pend_dir : key_dir;

endmodule

// File: rtl/frog_move_ctrl.sv
// Frog hop controller: IDLE -> HOP -> COOL FSM, position update and board-edge handling.
// Define FROG_WRAP_EN to make edge moves wrap around instead of being blocked.
module frog_move_ctrl
  import frog_pkg::*;
#(
  parameter int GRID_W      = 16,
  parameter int GRID_H      = 12,
  parameter int X_W         = 4,
  parameter int Y_W         = 4,
  parameter int START_X     = 7,
  parameter int START_Y     = 11,
  parameter int HOP_CYCLES  = 8,
  parameter int COOL_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_up,
  input  logic           key_down,
  input  logic           key_left,
  input  logic           key_right,
  input  logic           respawn,
  output logic [X_W-1:0] frog_x,
  output logic [Y_W-1:0] frog_y,
  output logic           hopping,
  output logic [1:0]     hop_dir,
  output logic           hop_done,
  output logic           blocked
);

  localparam logic [X_W-1:0]   X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]   X_START   = X_W'(START_X);
  localparam logic [Y_W-1:0]   Y_START   = Y_W'(START_Y);
  localparam logic [CNT_W-1:0] HOP_LOAD  = CNT_W'(HOP_CYCLES);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_CYCLES);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [X_W-1:0]   x_n, mv_x;
  logic [Y_W-1:0]   y_n, mv_y;
  logic [1:0]       dir_n;
  logic             done_n, blocked_n;
  logic             cmd_valid, consume, at_edge, legal;
  logic [1:0]       cmd_dir;

  frog_cmd_latch u_cmd_latch (
    .clk       (clk),
    .rst       (rst),
    .clr       (respawn),
    .busy      (state != ST_IDLE),
    .consume   (consume),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir)
  );

  // Edge test uses the incoming command; the move uses the latched hop direction.
  always_comb begin
    at_edge = 1'b0;
    mv_x    = frog_x;
    mv_y    = frog_y;
    case (cmd_dir)
      DIR_UP:   at_edge = (frog_y == '0);
      DIR_DOWN: at_edge = (frog_y == Y_MAX);
      DIR_LEFT: at_edge = (frog_x == '0);
      default:  at_edge = (frog_x == X_MAX);
    endcase
    case (hop_dir)
      DIR_UP:   mv_y = (frog_y == '0)    ? Y_MAX : frog_y - 1'b1;
      DIR_DOWN: mv_y = (frog_y == Y_MAX) ? '0    : frog_y + 1'b1;
      DIR_LEFT: mv_x = (frog_x == '0)    ? X_MAX : frog_x - 1'b1;
      default:  mv_x = (frog_x == X_MAX) ? '0    : frog_x + 1'b1;
    endcase
`ifdef FROG_WRAP_EN
    legal = 1'b1;
`else
    legal = !at_edge;
`endif
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    x_n       = frog_x;
    y_n       = frog_y;
    dir_n     = hop_dir;
    done_n    = 1'b0;
    blocked_n = 1'b0;
    consume   = 1'b0;
    if (respawn) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      x_n     = X_START;
      y_n     = Y_START;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            consume = 1'b1;
            if (legal) begin
              state_n = ST_HOP;
              cnt_n   = HOP_LOAD;
              dir_n   = cmd_dir;
            end else begin
              blocked_n = 1'b1;
            end
          end
        end
        ST_HOP: begin
          if (cnt <= 8'd1) begin
            state_n = ST_COOL;
            cnt_n   = COOL_LOAD;
            done_n  = 1'b1;
            x_n     = mv_x;
            y_n     = mv_y;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
        ST_COOL: begin
          if (cnt <= 8'd1) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      frog_x   <= X_START;
      frog_y   <= Y_START;
      hop_dir  <= DIR_UP;
      hop_done <= 1'b0;
      blocked  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      frog_x   <= x_n;
      frog_y   <= y_n;
      hop_dir  <= dir_n;
      hop_done <= done_n;
      blocked  <= blocked_n;
    end
  end

  assign hopping = (state == ST_HOP);

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Directed bench for frog_move_ctrl: single-key table plus multi-cycle sequences.
module tb_frog_move_ctrl;

`ifdef FROG_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       respawn = 1'b0;
  logic [3:0] frog_x;
  logic [3:0] frog_y;
  logic       hopping;
  logic [1:0] hop_dir;
  logic       hop_done;
  logic       blocked;

  int total = 0;
  int bad   = 0;

  frog_move_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .respawn   (respawn),
    .frog_x    (frog_x),
    .frog_y    (frog_y),
    .hopping   (hopping),
    .hop_dir   (hop_dir),
    .hop_done  (hop_done),
    .blocked   (blocked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] keys;   // {up, down, left, right}
    bit         hop;
    bit         blk;
    int         ex;
    int         ey;
    int         edir;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_up, key_down, key_left, key_right} = k;
  endtask

  task automatic do_reset();
    set_keys(4'b0000);
    respawn = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Press k once and wait until the FSM is back in IDLE (13 cycles later).
  task automatic press_and_settle(input logic [3:0] k);
    set_keys(k);
    step();
    set_keys(4'b0000);
    repeat (12) step();
  endtask

  initial begin
    int done_cnt;
    bit saw8;

    vecs[0] = '{4'b1000, 1'b1, 1'b0, 7, 10, 0};
    vecs[1] = '{4'b0100, WRAP, !WRAP, 7, WRAP ? 0 : 11, WRAP ? 1 : 0};
    vecs[2] = '{4'b0010, 1'b1, 1'b0, 6, 11, 2};
    vecs[3] = '{4'b0001, 1'b1, 1'b0, 8, 11, 3};
    vecs[4] = '{4'b1010, 1'b1, 1'b0, 7, 10, 0};
    vecs[5] = '{4'b0111, WRAP, !WRAP, 7, WRAP ? 0 : 11, WRAP ? 1 : 0};
    vecs[6] = '{4'b0011, 1'b1, 1'b0, 6, 11, 2};
    vecs[7] = '{4'b0000, 1'b0, 1'b0, 7, 11, 0};
    vecs[8] = '{4'b1111, 1'b1, 1'b0, 7, 10, 0};

    // Reset state, then 100 idle cycles with no keys.
    do_reset();
    chk("rst_x", frog_x, 7);
    chk("rst_y", frog_y, 11);
    chk("rst_dir", hop_dir, 0);
    for (int i = 0; i < 100; i++) begin
      chk("idle_hopping", hopping, 0);
      chk("idle_done", hop_done, 0);
      chk("idle_blocked", blocked, 0);
      chk("idle_x", frog_x, 7);
      chk("idle_y", frog_y, 11);
      step();
    end

    // Table: one key pattern from the start position, cycle-by-cycle profile.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      set_keys(vecs[v].keys);
      step();
      set_keys(4'b0000);
      for (int i = 1; i <= 14; i++) begin
        chk($sformatf("v%0d_hopping_c%0d", v, i), hopping, int'(vecs[v].hop && i <= 8));
        chk($sformatf("v%0d_done_c%0d", v, i), hop_done, int'(vecs[v].hop && i == 9));
        chk($sformatf("v%0d_blocked_c%0d", v, i), blocked, int'(vecs[v].blk && i == 1));
        chk($sformatf("v%0d_x_c%0d", v, i), frog_x, (i >= 9) ? vecs[v].ex : 7);
        chk($sformatf("v%0d_y_c%0d", v, i), frog_y, (i >= 9) ? vecs[v].ey : 11);
        step();
      end
      chk($sformatf("v%0d_dir", v), hop_dir, vecs[v].edir);
    end

    // Re-acceptance right after cooldown: key at t+13 launches at t+14.
    do_reset();
    set_keys(4'b1000);
    step();
    set_keys(4'b0000);
    repeat (12) step();
    chk("reacc_hopping_t13", hopping, 0);
    set_keys(4'b0010);
    step();
    set_keys(4'b0000);
    chk("reacc_hopping_t14", hopping, 1);
    repeat (8) step();
    chk("reacc_done_t22", hop_done, 1);
    chk("reacc_x_t22", frog_x, 6);
    chk("reacc_y_t22", frog_y, 10);

    // Pending buffer: left then right during a hop -> exactly one left hop.
    do_reset();
    set_keys(4'b1000);
    step();                      // t+1
    set_keys(4'b0000);
    step();                      // t+2
    set_keys(4'b0010);
    step();                      // t+3
    set_keys(4'b0000);
    step();                      // t+4
    set_keys(4'b0001);
    step();                      // t+5
    set_keys(4'b0000);
    done_cnt = 0;
    saw8 = 1'b0;
    for (int i = 5; i <= 40; i++) begin
      if (hop_done) done_cnt++;
      if (frog_x == 4'd8) saw8 = 1'b1;
      if (i == 14) chk("pend_hopping_t14", hopping, 1);
      if (i == 22) begin
        chk("pend_done_t22", hop_done, 1);
        chk("pend_x_t22", frog_x, 6);
        chk("pend_dir_t22", hop_dir, 2);
      end
      step();
    end
    chk("pend_done_count", done_cnt, 2);
    chk("pend_saw_x8", int'(saw8), 0);
    chk("pend_end_x", frog_x, 6);
    chk("pend_end_y", frog_y, 10);
    chk("pend_end_hopping", hopping, 0);

    // Top edge: climb to y=0, then a buffered up and a direct up.
    do_reset();
    for (int k = 0; k < 11; k++) press_and_settle(4'b1000);
    chk("edge_y0", frog_y, 0);
    set_keys(4'b0010);
    step();                      // t+1
    set_keys(4'b0000);
    step();
    step();                      // t+3
    set_keys(4'b1000);
    step();                      // t+4
    set_keys(4'b0000);
    repeat (10) step();          // t+14
    chk("edge_pend_blocked_t14", blocked, int'(!WRAP));
    chk("edge_pend_hopping_t14", hopping, int'(WRAP));
    chk("edge_pend_x_t14", frog_x, 6);
    step();                      // t+15
    chk("edge_pend_blocked_t15", blocked, 0);
    repeat (8) step();           // t+23
    chk("edge_pend_y_t23", frog_y, WRAP ? 11 : 0);
    repeat (3) step();           // t+26, IDLE in both builds
    set_keys(4'b1000);
    step();
    set_keys(4'b0000);
    chk("edge_up_blocked", blocked, int'(!WRAP));
    chk("edge_up_hopping", hopping, int'(WRAP));
    step();
    chk("edge_up_blocked_once", blocked, 0);
    repeat (11) step();
    chk("edge_up_y", frog_y, WRAP ? 10 : 0);

    // Respawn mid-hop from (7,10) with a pending key: everything dropped.
    do_reset();
    press_and_settle(4'b1000);
    chk("resp_pre_y", frog_y, 10);
    set_keys(4'b1000);
    step();                      // t+1
    set_keys(4'b0000);
    step();                      // t+2
    set_keys(4'b0010);
    step();                      // t+3
    set_keys(4'b0000);
    step();                      // t+4
    respawn = 1'b1;
    set_keys(4'b0001);
    step();                      // t+5
    respawn = 1'b0;
    set_keys(4'b0000);
    chk("resp_x", frog_x, 7);
    chk("resp_y", frog_y, 11);
    chk("resp_hopping", hopping, 0);
    chk("resp_done", hop_done, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("resp_after_hopping", hopping, 0);
      chk("resp_after_done", hop_done, 0);
      chk("resp_after_x", frog_x, 7);
    end

    // Asynchronous reset mid-hop takes effect without a clock edge.
    set_keys(4'b0010);
    step();
    set_keys(4'b0000);
    step();
    chk("arst_pre_hopping", hopping, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hopping", hopping, 0);
    chk("arst_x", frog_x, 7);
    chk("arst_y", frog_y, 11);
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
